data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//   Shares the single-port 4096x32 data BRAM between two requesters: port 0 (CPU load/store
//   unit) and port 1 (debug/DMA). Round-robin arbitration, one access per cycle, with a
//   per-port lock for atomic read-modify-write sequences and a lock-timeout watchdog.
//   Drives the BRAM we/addr/wdata/wstrb pins, returns its registered read data, and
//   counts cycles lost to contention.
// PARAMETERS
//   LOCK_TIMEOUT  16  max consecutive LOCKED cycles with no owner access before forced release
//   CNT_W         16  width of conflict_cnt (saturating)
// PORTS
//   clk           in   1   clock, all logic on posedge
//   rst_n         in   1   asynchronous active-low reset
//   mN_req        in   1   port N (N=0,1) request; access accepted when mN_req & mN_gnt
//   mN_we         in   1   port N write (1) / read (0)
//   mN_addr       in   12  port N word address
//   mN_wdata      in   32  port N write data
//   mN_wstrb      in   4   port N byte strobes (bit i = byte i)
//   mN_lock       in   1   port N: hold ownership after this access
//   mN_gnt        out  1   port N grant, combinational, same cycle as request
//   mN_rvalid     out  1   port N response, exactly 1 cycle after acceptance
//   mN_rdata      out  32  port N read data, valid with mN_rvalid
//   mem_we        out  1   to BRAM we
//   mem_addr      out  12  to BRAM addr
//   mem_wdata     out  32  to BRAM wdata
//   mem_wstrb     out  4   to BRAM wstrb
//   mem_rdata     in   32  from BRAM registered rdata (1-cycle latency)
//   lock_err      out  1   1-cycle pulse on lock-timeout release
//   conflict_cnt  out  CNT_W  cycles where some port had req=1 and gnt=0; saturates at all-ones
// BEHAVIOUR
//   Reset: state=IDLE, last_gnt=1 (port 0 wins the first conflict), rvalid regs=0,
//     lock_err=0, conflict_cnt=0, timeout counter=0. Reset mid-access drops pending rvalid.
//   Grant (IDLE): only one req -> grant it; both -> grant port != last_gnt.
//     On acceptance last_gnt <= granted port. At most one gnt high per cycle.
//   mem_* driven combinationally from the granted port; mem_we = req&gnt&we. With no grant:
//     mem_we=0, mem_addr/wdata/wstrb=0.
//   Response: rvalid_N <= accepted_N, registered. mN_rdata = mem_rdata for both ports.
//     Writes also get rvalid (ack); rdata on a write ack is the pre-write word (read-first BRAM).
//     Back-to-back accesses every cycle allowed; no bubbles.
//   FSM states IDLE, LOCK0, LOCK1:
//     IDLE  -> LOCKn when port n accepted with mN_lock=1.
//     LOCKn: only port n may be granted (other gnt=0 even if requesting).
//       Owner accepted with lock=0 -> IDLE (that access still performed).
//       Owner accepted with lock=1 -> stay, timeout counter cleared.
//       No owner access -> counter++; reaching LOCK_TIMEOUT -> IDLE, lock_err=1 one cycle.
//     Timeout counter cleared on every state entry.
//   conflict_cnt increments by 1 per cycle (not per port) when (m0_req&!m0_gnt)|(m1_req&!m1_gnt).
//   Requester must hold req/addr/data stable until gnt; arbiter does not buffer.
// TESTING
//   Single read: m0 read addr 0x010 (mem holds 0xDEADBEEF) -> m0_gnt same cycle,
//     m0_rvalid=1, m0_rdata=0xDEADBEEF next cycle, m1_rvalid stays 0.
//   Contention: both req every cycle for 6 cycles from reset -> grants alternate 0,1,0,1,0,1;
//     conflict_cnt=6.
//   Byte write: m1 write addr 0x020 wdata 0x11223344 wstrb 4'b0010 over 0xAAAAAAAA,
//     then read -> 0xAAAA33AA.
//   Lock: m0 lock=1 read, m1 requesting continuously, m0 write lock=0 two cycles later
//     -> m1_gnt=0 throughout, granted the cycle after m0's unlock write.
//   Timeout: m0 lock=1 access then idle, m1 requesting -> after 16 cycles lock_err pulses,
//     m1_gnt=1 next cycle.
//   Reset: assert rst_n=0 the cycle after an accepted read -> no rvalid; all outputs 0.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// ============================================================================
// Module   : data_mem_arbiter_if
// Brief    : Requester-side bus of the data BRAM arbiter (one instance per port)
// Revision : 1.0
// ============================================================================
`default_nettype none

interface data_mem_arbiter_if;
    logic        req;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        lock;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, wstrb, lock,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb, lock,
        output gnt, rvalid, rdata
    );
endinterface

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// ============================================================================
// Module   : data_mem_arbiter
// Brief    : Round-robin two-port arbiter for the 4096x32 data BRAM with
//            per-port lock, lock-timeout watchdog and contention counter
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_mem_arbiter #(
    parameter int LOCK_TIMEOUT = 16,
    parameter int CNT_W        = 16
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    data_mem_arbiter_if.slave    m0,
    data_mem_arbiter_if.slave    m1,
    output logic                 mem_we,
    output logic [11:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_wstrb,
    input  wire logic [31:0]     mem_rdata,
    output logic                 lock_err,
    output logic [CNT_W-1:0]     conflict_cnt
);

    localparam int c_tmo_w = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_last_gnt;
    logic                r_rvalid0;
    logic                r_rvalid1;
    logic                r_lock_err;
    logic [c_tmo_w-1:0]  r_tmo_cnt;
    logic [CNT_W-1:0]    r_conflict_cnt;

    logic w_gnt0;
    logic w_gnt1;
    logic w_acc0;
    logic w_acc1;
    logic w_conflict;
    logic w_own_acc;
    logic w_own_lock;

    // In IDLE a conflict goes to the port that did not win last; a lock
    // restricts grants to its owner only.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            IDLE: begin
                if (m0.req && m1.req) begin
                    w_gnt0 = r_last_gnt;
                    w_gnt1 = ~r_last_gnt;
                end else begin
                    w_gnt0 = m0.req;
                    w_gnt1 = m1.req;
                end
            end
            LOCK0:   w_gnt0 = m0.req;
            LOCK1:   w_gnt1 = m1.req;
            default: ;
        endcase
    end

    assign w_acc0     = m0.req & w_gnt0;
    assign w_acc1     = m1.req & w_gnt1;
    assign w_conflict = (m0.req & ~w_gnt0) | (m1.req & ~w_gnt1);
    assign w_own_acc  = (r_state == LOCK0) ? w_acc0  : w_acc1;
    assign w_own_lock = (r_state == LOCK0) ? m0.lock : m1.lock;

    assign mem_we    = w_acc0 ? m0.we    : (w_acc1 ? m1.we    : 1'b0);
    assign mem_addr  = w_acc0 ? m0.addr  : (w_acc1 ? m1.addr  : 12'd0);
    assign mem_wdata = w_acc0 ? m0.wdata : (w_acc1 ? m1.wdata : 32'd0);
    assign mem_wstrb = w_acc0 ? m0.wstrb : (w_acc1 ? m1.wstrb : 4'd0);

    assign m0.gnt    = w_gnt0;
    assign m1.gnt    = w_gnt1;
    assign m0.rvalid = r_rvalid0;
    assign m1.rvalid = r_rvalid1;
    assign m0.rdata  = mem_rdata;
    assign m1.rdata  = mem_rdata;

    assign lock_err     = r_lock_err;
    assign conflict_cnt = r_conflict_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_last_gnt     <= 1'b1;
            r_rvalid0      <= 1'b0;
            r_rvalid1      <= 1'b0;
            r_lock_err     <= 1'b0;
            r_tmo_cnt      <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_rvalid0  <= w_acc0;
            r_rvalid1  <= w_acc1;
            r_lock_err <= 1'b0;

            if (w_acc0) begin
                r_last_gnt <= 1'b0;
            end else if (w_acc1) begin
                r_last_gnt <= 1'b1;
            end

            if (w_conflict && (r_conflict_cnt != {CNT_W{1'b1}})) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_acc0 && m0.lock) begin
                        r_state   <= LOCK0;
                        r_tmo_cnt <= '0;
                    end else if (w_acc1 && m1.lock) begin
                        r_state   <= LOCK1;
                        r_tmo_cnt <= '0;
                    end
                end
                LOCK0, LOCK1: begin
                    if (w_own_acc) begin
                        if (!w_own_lock) begin
                            r_state <= IDLE;
                        end
                        r_tmo_cnt <= '0;
                    end else if (r_tmo_cnt == c_tmo_w'(LOCK_TIMEOUT - 1)) begin
                        // Owner went silent too long: force release and flag it.
                        r_state    <= IDLE;
                        r_tmo_cnt  <= '0;
                        r_lock_err <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_tmo_cnt <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// ============================================================================
// Module   : tb_data_mem_arbiter
// Brief    : Directed scoreboard bench for data_mem_arbiter with a BRAM model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        lock_err;
    logic [15:0] conflict_cnt;

    data_mem_arbiter_if m0_if ();
    data_mem_arbiter_if m1_if ();

    data_mem_arbiter #(.LOCK_TIMEOUT(16), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0           (m0_if),
        .m1           (m1_if),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata),
        .lock_err     (lock_err),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first BRAM model with a bench-side preload port.
    logic [31:0] bram [0:4095];
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        mem_rdata <= bram[mem_addr];
        if (pl_en) begin
            bram[pl_addr] <= pl_data;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    logic [31:0] ref_mem [0:4095];
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        pend0, pend1;
    logic [31:0] last_rdata1;
    int          n_checks;
    int          n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic drv0(input logic req, input logic we, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic lk);
        m0_if.req = req; m0_if.we = we; m0_if.addr = a;
        m0_if.wdata = d; m0_if.wstrb = s; m0_if.lock = lk;
    endtask

    task automatic drv1(input logic req, input logic we, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic lk);
        m1_if.req = req; m1_if.we = we; m1_if.addr = a;
        m1_if.wdata = d; m1_if.wstrb = s; m1_if.lock = lk;
    endtask

    task automatic ref_access(input logic we, input logic [11:0] a,
                              input logic [31:0] d, input logic [3:0] s, output logic [31:0] old);
        old = ref_mem[a];
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    // One bus cycle: check responses due now, check grants and BRAM pins,
    // then record accepted accesses in the scoreboard.
    task automatic tick(input logic eg0, input logic eg1, input logic elerr);
        logic [31:0] old;
        logic acc0, acc1;
        @(negedge clk);
        check("m0_rvalid", {31'd0, m0_if.rvalid}, {31'd0, pend0});
        check("m1_rvalid", {31'd0, m1_if.rvalid}, {31'd0, pend1});
        if (pend0 && m0_if.rvalid) begin
            if (q0.size() == 0) check("m0_queue_empty", 32'd1, 32'd0);
            else check("m0_rdata", m0_if.rdata, q0.pop_front());
        end
        if (pend1 && m1_if.rvalid) begin
            last_rdata1 = m1_if.rdata;
            if (q1.size() == 0) check("m1_queue_empty", 32'd1, 32'd0);
            else check("m1_rdata", m1_if.rdata, q1.pop_front());
        end
        check("m0_gnt", {31'd0, m0_if.gnt}, {31'd0, eg0});
        check("m1_gnt", {31'd0, m1_if.gnt}, {31'd0, eg1});
        check("lock_err", {31'd0, lock_err}, {31'd0, elerr});
        acc0 = eg0 & m0_if.req;
        acc1 = eg1 & m1_if.req;
        if (acc0) begin
            check("mem_addr_p0", {20'd0, mem_addr}, {20'd0, m0_if.addr});
            check("mem_we_p0", {31'd0, mem_we}, {31'd0, m0_if.we});
            if (m0_if.we) check("mem_wdata_p0", mem_wdata, m0_if.wdata);
            ref_access(m0_if.we, m0_if.addr, m0_if.wdata, m0_if.wstrb, old);
            q0.push_back(old);
        end else if (acc1) begin
            check("mem_addr_p1", {20'd0, mem_addr}, {20'd0, m1_if.addr});
            check("mem_we_p1", {31'd0, mem_we}, {31'd0, m1_if.we});
            if (m1_if.we) begin
                check("mem_wdata_p1", mem_wdata, m1_if.wdata);
                check("mem_wstrb_p1", {28'd0, mem_wstrb}, {28'd0, m1_if.wstrb});
            end
            ref_access(m1_if.we, m1_if.addr, m1_if.wdata, m1_if.wstrb, old);
            q1.push_back(old);
        end else begin
            check("mem_we_idle", {31'd0, mem_we}, 32'd0);
            check("mem_addr_idle", {20'd0, mem_addr}, 32'd0);
        end
        pend0 = acc0;
        pend1 = acc1;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m0_rvalid"}, {31'd0, m0_if.rvalid}, 32'd0);
        check({tag, "_m1_rvalid"}, {31'd0, m1_if.rvalid}, 32'd0);
        check({tag, "_gnt"}, {30'd0, m1_if.gnt, m0_if.gnt}, 32'd0);
        check({tag, "_lock_err"}, {31'd0, lock_err}, 32'd0);
        check({tag, "_conflict"}, {16'd0, conflict_cnt}, 32'd0);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_addr"}, {20'd0, mem_addr}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drv0(0, 0, 12'd0, 32'd0, 4'd0, 0);
        drv1(0, 0, 12'd0, 32'd0, 4'd0, 0);
        @(negedge clk);
        check_reset_outputs("reset");
        q0.delete(); q1.delete();
        pend0 = 1'b0; pend1 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        n_checks = 0; n_err = 0;
        pend0 = 1'b0; pend1 = 1'b0;
        last_rdata1 = 32'd0;
        pl_en = 1'b0; pl_addr = 12'd0; pl_data = 32'd0;
        rst_n = 1'b0;
        drv0(0, 0, 12'd0, 32'd0, 4'd0, 0);
        drv1(0, 0, 12'd0, 32'd0, 4'd0, 0);
        @(posedge clk); #1;
        preload(12'h000, 32'h0000_0000);
        preload(12'h010, 32'hDEAD_BEEF);
        preload(12'h020, 32'hAAAA_AAAA);
        preload(12'h030, 32'h0BAD_F00D);
        for (int i = 0; i < 6; i++) begin
            preload(12'h100 + 12'(i), 32'h1000_0000 + 32'(i));
            preload(12'h200 + 12'(i), 32'h2000_0000 + 32'(i));
        end
        do_reset();

        // Contention from reset: grants alternate starting with port 0.
        for (int i = 0; i < 6; i++) begin
            drv0(1, 0, 12'h100 + 12'(i), 32'd0, 4'd0, 0);
            drv1(1, 0, 12'h200 + 12'(i), 32'd0, 4'd0, 0);
            tick(i % 2 == 0, i % 2 == 1, 0);
        end
        drv0(0, 0, 12'd0, 32'd0, 4'd0, 0);
        drv1(0, 0, 12'd0, 32'd0, 4'd0, 0);
        tick(0, 0, 0);
        check("conflict_cnt_6", {16'd0, conflict_cnt}, 32'd6);

        // Single read.
        drv0(1, 0, 12'h010, 32'd0, 4'd0, 0);
        tick(1, 0, 0);
        drv0(0, 0, 12'd0, 32'd0, 4'd0, 0);
        tick(0, 0, 0);

        // Byte-strobed write then read back.
        drv1(1, 1, 12'h020, 32'h1122_3344, 4'b0010, 0);
        tick(0, 1, 0);
        drv1(1, 0, 12'h020, 32'd0, 4'd0, 0);
        tick(0, 1, 0);
        check("write_ack_preword", last_rdata1, 32'hAAAA_AAAA);
        drv1(0, 0, 12'd0, 32'd0, 4'd0, 0);
        tick(0, 0, 0);
        check("bytewrite_merge", last_rdata1, 32'hAAAA_33AA);

        // Lock: m1 locked out until the cycle after m0's unlocking write.
        do_reset();
        drv0(1, 0, 12'h010, 32'd0, 4'd0, 1);
        drv1(1, 0, 12'h020, 32'd0, 4'd0, 0);
        tick(1, 0, 0);
        drv0(0, 0, 12'd0, 32'd0, 4'd0, 0);
        tick(0, 0, 0);
        drv0(1, 1, 12'h030, 32'h5555_5555, 4'hF, 0);
        tick(1, 0, 0);
        drv0(0, 0, 12'd0, 32'd0, 4'd0, 0);
        tick(0, 1, 0);
        drv1(0, 0, 12'd0, 32'd0, 4'd0, 0);
        tick(0, 0, 0);

        // Lock timeout after 16 idle owner cycles.
        do_reset();
        drv0(1, 0, 12'h010, 32'd0, 4'd0, 1);
        drv1(1, 0, 12'h020, 32'd0, 4'd0, 0);
        tick(1, 0, 0);
        drv0(0, 0, 12'd0, 32'd0, 4'd0, 0);
        for (int i = 0; i < 16; i++) tick(0, 0, 0);
        tick(0, 1, 1);
        drv1(0, 0, 12'd0, 32'd0, 4'd0, 0);
        tick(0, 0, 0);

        // Reset right behind an accepted read drops its response.
        drv0(1, 0, 12'h010, 32'd0, 4'd0, 0);
        @(negedge clk);
        check("midrst_gnt", {31'd0, m0_if.gnt}, 32'd1);
        rst_n = 1'b0;
        drv0(0, 0, 12'd0, 32'd0, 4'd0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("midrst");
        q0.delete(); q1.delete();
        pend0 = 1'b0; pend1 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tick(0, 0, 0);

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
